receive_fsm: RTL and testbench



---
 rtl/receive_fsm_if.sv | 21 ++
 rtl/receive_fsm.sv | 107 ++++++++++
 tb/tb_receive_fsm.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/receive_fsm_if.sv
// Byte-in / command-out handshake between the UART receiver, the command
// parser and the acquisition control logic.
interface receive_fsm_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic [15:0] cmd_arg;
  logic        frame_err;
  logic        busy;

  modport master (
    output rx_valid, rx_data,
    input  cmd_valid, cmd_code, cmd_arg, frame_err, busy
  );

  modport slave (
    input  rx_valid, rx_data,
    output cmd_valid, cmd_code, cmd_arg, frame_err, busy
  );
endinterface

// File: rtl/receive_fsm.sv
// Host-command receiver: parses SYNC/CODE/ARG_HI/ARG_LO/CHK frames, checks
// the XOR checksum and emits validated commands as single-cycle strobes.
module receive_fsm #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic           clk,
  input  logic           rst_n,
  receive_fsm_if.slave   bus
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CODE,
    S_ARG_HI,
    S_ARG_LO,
    S_CHK
  } state_t;

  state_t        r_state;
  logic [7:0]    r_xor;
  logic [7:0]    r_code_sh;
  logic [15:0]   r_arg_sh;
  logic [CW-1:0] r_cnt;
  logic          r_cmd_valid;
  logic          r_frame_err;
  logic          r_busy;
  logic [7:0]    r_cmd_code;
  logic [15:0]   r_cmd_arg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_xor       <= '0;
      r_code_sh   <= '0;
      r_arg_sh    <= '0;
      r_cnt       <= '0;
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_code  <= '0;
      r_cmd_arg   <= '0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_state == S_IDLE) begin
        if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
          r_state <= S_CODE;
          r_busy  <= 1'b1;
          r_xor   <= '0;
          r_cnt   <= '0;
        end
      end else if (bus.rx_valid) begin
        // A byte on the terminal-count cycle takes priority over the timeout.
        r_cnt <= '0;
        case (r_state)
          S_CODE: begin
            r_code_sh <= bus.rx_data;
            r_xor     <= r_xor ^ bus.rx_data;
            r_state   <= S_ARG_HI;
          end
          S_ARG_HI: begin
            r_arg_sh[15:8] <= bus.rx_data;
            r_xor          <= r_xor ^ bus.rx_data;
            r_state        <= S_ARG_LO;
          end
          S_ARG_LO: begin
            r_arg_sh[7:0] <= bus.rx_data;
            r_xor         <= r_xor ^ bus.rx_data;
            r_state       <= S_CHK;
          end
          default: begin
            if (bus.rx_data == r_xor) begin
              r_cmd_code  <= r_code_sh;
              r_cmd_arg   <= r_arg_sh;
              r_cmd_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end else if (r_cnt == TERM) begin
        r_frame_err <= 1'b1;
        r_state     <= S_IDLE;
        r_busy      <= 1'b0;
        r_cnt       <= '0;
        r_xor       <= '0;
        r_code_sh   <= '0;
        r_arg_sh    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign bus.cmd_valid = r_cmd_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = r_busy;
  assign bus.cmd_code  = r_cmd_code;
  assign bus.cmd_arg   = r_cmd_arg;

endmodule

// File: tb/tb_receive_fsm.sv
// Directed bench for receive_fsm: frames, checksum errors, timeout,
// back-to-back frames and mid-frame reset.
module tb_receive_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  receive_fsm_if bus ();

  receive_fsm #(
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(20)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Caller is at a negedge; byte is accepted at the following posedge and
  // the task returns at the negedge after it.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  // Idle for n cycles, counting any pulse seen on cmd_valid/frame_err.
  task automatic gap(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.cmd_valid || bus.frame_err) pulses++;
    end
  endtask

  task automatic test_reset();
    int p;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cmd_valid, bus.frame_err, bus.busy, bus.cmd_code, bus.cmd_arg} !== 27'h0) begin
      errors++;
      $display("FAIL reset_state: got v=%b e=%b b=%b code=%h arg=%h, want all 0",
               bus.cmd_valid, bus.frame_err, bus.busy, bus.cmd_code, bus.cmd_arg);
    end
    rst_n = 1'b1;
    gap(3, p);
    checks++;
    if (p !== 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_exit: got pulses=%0d busy=%b, want 0/0", p, bus.busy);
    end
  endtask

  task automatic test_valid_frame();
    logic [7:0] f [5] = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h27};
    int p;
    int bad_busy = 0;
    int pulses = 0;
    for (int i = 0; i < 5; i++) begin
      send_byte(f[i]);
      if (i < 4) begin
        if (bus.busy !== 1'b1) bad_busy++;
        if (bus.cmd_valid || bus.frame_err) pulses++;
        gap(15, p);
        pulses += p;
        if (bus.busy !== 1'b1) bad_busy++;
      end
    end
    checks++;
    if (bad_busy !== 0 || pulses !== 0) begin
      errors++;
      $display("FAIL valid_in_frame: got busy_low=%0d pulses=%0d, want 0/0", bad_busy, pulses);
    end
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.frame_err !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL valid_pulse: got v=%b e=%b b=%b, want 1/0/0",
               bus.cmd_valid, bus.frame_err, bus.busy);
    end
    checks++;
    if (bus.cmd_code !== 8'h01 || bus.cmd_arg !== 16'h1234) begin
      errors++;
      $display("FAIL valid_data: got code=%h arg=%h, want 01/1234", bus.cmd_code, bus.cmd_arg);
    end
    @(negedge clk);
    checks++;
    if (bus.cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_one_cycle: got v=%b, want 0", bus.cmd_valid);
    end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] f [5] = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h00};
    for (int i = 0; i < 5; i++) send_byte(f[i]);
    checks++;
    if (bus.frame_err !== 1'b1 || bus.cmd_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL badchk_pulse: got e=%b v=%b b=%b, want 1/0/0",
               bus.frame_err, bus.cmd_valid, bus.busy);
    end
    checks++;
    if (bus.cmd_code !== 8'h01 || bus.cmd_arg !== 16'h1234) begin
      errors++;
      $display("FAIL badchk_hold: got code=%h arg=%h, want 01/1234", bus.cmd_code, bus.cmd_arg);
    end
    @(negedge clk);
    checks++;
    if (bus.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL badchk_one_cycle: got e=%b, want 0", bus.frame_err);
    end
  endtask

  task automatic test_garbage_then_frame();
    logic [7:0] g [3] = '{8'h00, 8'hFF, 8'h5A};
    logic [7:0] f [5] = '{8'hA5, 8'h03, 8'hAB, 8'hCD, 8'h65};
    int p;
    int pulses = 0;
    int busy_hi = 0;
    for (int i = 0; i < 3; i++) begin
      send_byte(g[i]);
      if (bus.busy) busy_hi++;
      gap(2, p);
      pulses += p;
    end
    checks++;
    if (pulses !== 0 || busy_hi !== 0) begin
      errors++;
      $display("FAIL garbage_quiet: got pulses=%0d busy_hi=%0d, want 0/0", pulses, busy_hi);
    end
    for (int i = 0; i < 5; i++) send_byte(f[i]);
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 8'h03 || bus.cmd_arg !== 16'hABCD) begin
      errors++;
      $display("FAIL garbage_frame: got v=%b code=%h arg=%h, want 1/03/ABCD",
               bus.cmd_valid, bus.cmd_code, bus.cmd_arg);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [7:0] f [5] = '{8'hA5, 8'h04, 8'h00, 8'h01, 8'h05};
    int early = 0;
    int p;
    send_byte(8'hA5);
    send_byte(8'h04);
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      if (bus.frame_err || !bus.busy) early++;
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL timeout_early: got %0d premature cycles, want 0", early);
    end
    @(negedge clk);
    checks++;
    if (bus.frame_err !== 1'b1 || bus.busy !== 1'b0 || bus.cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: got e=%b b=%b v=%b, want 1/0/0",
               bus.frame_err, bus.busy, bus.cmd_valid);
    end
    gap(3, p);
    checks++;
    if (p !== 0) begin
      errors++;
      $display("FAIL timeout_once: got %0d extra pulses, want 0", p);
    end
    for (int i = 0; i < 5; i++) send_byte(f[i]);
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 8'h04 || bus.cmd_arg !== 16'h0001) begin
      errors++;
      $display("FAIL timeout_recover: got v=%b code=%h arg=%h, want 1/04/0001",
               bus.cmd_valid, bus.cmd_code, bus.cmd_arg);
    end
    @(negedge clk);
    // Byte landing on the terminal-count edge must win over the timeout.
    send_byte(8'hA5);
    send_byte(8'h04);
    gap(19, p);
    send_byte(8'h00);
    checks++;
    if (p !== 0 || bus.frame_err !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_edge_byte: got pulses=%0d e=%b b=%b, want 0/0/1",
               p, bus.frame_err, bus.busy);
    end
    send_byte(8'h01);
    send_byte(8'h05);
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_arg !== 16'h0001) begin
      errors++;
      $display("FAIL timeout_edge_frame: got v=%b arg=%h, want 1/0001", bus.cmd_valid, bus.cmd_arg);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] f [10] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5,
                           8'hA5, 8'h10, 8'h00, 8'h00, 8'h10};
    for (int i = 0; i < 10; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = f[i];
      @(negedge clk);
      if (i == 4) begin
        checks++;
        if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 8'hA5 || bus.cmd_arg !== 16'hA5A5) begin
          errors++;
          $display("FAIL b2b_first: got v=%b code=%h arg=%h, want 1/A5/A5A5",
                   bus.cmd_valid, bus.cmd_code, bus.cmd_arg);
        end
      end
      if (i == 5) begin
        checks++;
        if (bus.cmd_valid !== 1'b0 || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_resync: got v=%b b=%b, want 0/1", bus.cmd_valid, bus.busy);
        end
      end
    end
    bus.rx_valid = 1'b0;
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 8'h10 || bus.cmd_arg !== 16'h0000) begin
      errors++;
      $display("FAIL b2b_second: got v=%b code=%h arg=%h, want 1/10/0000",
               bus.cmd_valid, bus.cmd_code, bus.cmd_arg);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] f [5] = '{8'hA5, 8'h07, 8'h11, 8'h22, 8'h34};
    int p;
    int pulses = 0;
    send_byte(8'hA5);
    send_byte(8'h07);
    send_byte(8'h11);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.cmd_code !== 8'h00 || bus.cmd_arg !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_state: got b=%b code=%h arg=%h, want 0/00/0000",
               bus.busy, bus.cmd_code, bus.cmd_arg);
    end
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h22);
    if (bus.cmd_valid || bus.frame_err || bus.busy) pulses++;
    send_byte(8'h33);
    if (bus.cmd_valid || bus.frame_err || bus.busy) pulses++;
    gap(3, p);
    pulses += p;
    checks++;
    if (pulses !== 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet: got activity=%0d b=%b, want 0/0", pulses, bus.busy);
    end
    for (int i = 0; i < 5; i++) send_byte(f[i]);
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 8'h07 || bus.cmd_arg !== 16'h1122) begin
      errors++;
      $display("FAIL midreset_frame: got v=%b code=%h arg=%h, want 1/07/1122",
               bus.cmd_valid, bus.cmd_code, bus.cmd_arg);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_garbage_then_frame();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
